// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage LEGv8 core: resolves load-use hazards,
// taken-branch flushes and multi-cycle data-memory waits, and counts stall cycles.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_MemRead,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rn,
    input  logic [4:0]       if_id_rm,
    input  logic             if_id_uses_rm,
    input  logic             branch_taken,
    input  logic             ex_mem_MemRead,
    input  logic             ex_mem_MemWrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

    localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic memop;
    logic lu_haz;

    assign memop  = ex_mem_MemRead | ex_mem_MemWrite;
    assign lu_haz = id_ex_MemRead && (id_ex_rd != 5'd31) &&
                    ((id_ex_rd == if_id_rn) || (if_id_uses_rm && (id_ex_rd == if_id_rm)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        dmem_req      = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;

        case (state_q)
            RUN, MEM_WAIT: begin
                dmem_req = memop;
                if ((state_q == RUN && memop && !dmem_ready) ||
                    (state_q == MEM_WAIT && !dmem_ready)) begin
                    // Freeze everything up to EX/MEM; MEM/WB receives a bubble.
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    if (state_q == RUN) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = 8'd0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d   = MEM_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    state_d = RUN;
                    if (branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (lu_haz) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
            end
            default: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
            end
        endcase

        // While reset is held the pipeline runs freely with no memory request.
        if (!reset) begin
            dmem_req      = 1'b0;
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            id_ex_en      = 1'b1;
            ex_mem_en     = 1'b1;
            if_id_flush   = 1'b0;
            id_ex_bubble  = 1'b0;
            mem_wb_bubble = 1'b0;
        end

        stall_count_d = stall_count_q;
        if (!pc_en && stall_count_q != CNT_MAX)
            stall_count_d = stall_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_err_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mem_err     = mem_err_q;
    assign stall_count = stall_count_q;

endmodule
